// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction SRAM request/response, redirect input and decode handshake.
// The master modport is the fetch unit's view; the slave modport is its environment's view.
interface fetch_if;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   modport master (
      output inst_sram_en, inst_sram_addr, out_valid, out_pc, out_inst,
      input  inst_sram_rdata, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  inst_sram_en, inst_sram_addr, out_valid, out_pc, out_inst,
      output inst_sram_rdata, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word reads to a 1-cycle-latency SRAM and buffers up to two
// {pc, inst} pairs for decode, with single-cycle redirect that flushes all buffered work.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
   input logic    clk,
   input logic    reset,
   fetch_if.master bus_io
);

   typedef enum logic {StBoot = 1'b0, StRun = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] req_pc_q;
   logic        inflight_q;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [31:0] pc_mem_q   [2];
   logic [31:0] inst_mem_q [2];

   logic        run, redir, out_valid, pop, push, issue;
   logic [2:0]  occupancy;

   always_comb begin
      state_d   = state_q;
      fpc_d     = fpc_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;

      unique case (state_q)
         StBoot:  state_d = StRun;
         StRun:   state_d = StRun;
         default: state_d = StBoot;
      endcase

      run       = (state_q == StRun) & ~reset;
      redir     = run & bus_io.redirect_valid;
      out_valid = (count_q != 2'd0) & ~bus_io.redirect_valid & ~reset;
      pop       = out_valid & bus_io.out_ready;
      // A response landing in a redirect cycle belongs to the abandoned path.
      push      = inflight_q & ~redir & ~reset;
      occupancy = {1'b0, count_q} + {2'b00, inflight_q};
      issue     = run & ~bus_io.redirect_valid &
                  ((occupancy < 3'd2) | ((occupancy == 3'd2) & pop));

      if (redir) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         fpc_d    = bus_io.redirect_pc & 32'hffff_fffc;
      end else begin
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop) rd_ptr_d = ~rd_ptr_q;
         if (issue) fpc_d = fpc_q + 32'd4;
      end

      bus_io.inst_sram_en   = issue;
      bus_io.inst_sram_addr = fpc_q;
      bus_io.out_valid      = out_valid;
      bus_io.out_pc         = pc_mem_q[rd_ptr_q];
      bus_io.out_inst       = inst_mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StBoot;
         fpc_q      <= RESET_PC;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fpc_q      <= fpc_d;
         inflight_q <= issue;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Payload storage needs no reset; count_q qualifies every read.
   always_ff @(posedge clk) begin
      if (issue) req_pc_q <= fpc_q;
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= req_pc_q;
         inst_mem_q[wr_ptr_q] <= bus_io.inst_sram_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked by a program-order
// scoreboard that predicts the instruction stream from the reset/redirect history alone.
module tb_fetch_unit;
   localparam logic [31:0] RstPc = 32'h1c00_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rst_prev = 1'b1;
   bit   hash_mode = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   xfers = 0;

   ent_t        exp_q[$];
   logic [31:0] next_pc = RstPc;

   always #5 clk = ~clk;

   fetch_if bus();

   fetch_unit #(.RESET_PC(RstPc)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return hash_mode ? ((a * 32'h9e37_79b1) ^ 32'h5a5a_0f0f) : a;
   endfunction

   function automatic void top_up();
      while (exp_q.size() < 4) begin
         exp_q.push_back({next_pc, mem_word(next_pc)});
         next_pc = next_pc + 32'd4;
      end
   endfunction

   function automatic void restart(input logic [31:0] pc);
      exp_q.delete();
      next_pc = pc & 32'hffff_fffc;
      top_up();
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // SRAM environment: one-cycle read latency, garbage when not read.
   always @(posedge clk) begin
      rst_prev <= reset;
      if (bus.inst_sram_en) bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
      else bus.inst_sram_rdata <= $urandom;
   end

   // Monitor: judges the cycle at mid-period, inputs having settled after the rising edge.
   logic        held_valid = 1'b0;
   logic [31:0] held_pc, held_inst;
   int          stall = 0;

   always @(negedge clk) begin
      logic in_boot, redir;
      ent_t e;
      in_boot = rst_prev && !reset;
      redir   = bus.redirect_valid && !reset && !rst_prev;
      if (reset || in_boot) begin
         chk("reset_en", 32'(bus.inst_sram_en), 32'd0);
         chk("reset_valid", 32'(bus.out_valid), 32'd0);
      end else if (redir) begin
         chk("redir_en", 32'(bus.inst_sram_en), 32'd0);
         chk("redir_valid", 32'(bus.out_valid), 32'd0);
      end
      if (bus.inst_sram_en) chk("addr_align", 32'(bus.inst_sram_addr[1:0]), 32'd0);
      if (held_valid && bus.out_valid) begin
         chk("hold_pc", bus.out_pc, held_pc);
         chk("hold_inst", bus.out_inst, held_inst);
      end
      held_valid = bus.out_valid && !bus.out_ready && !reset;
      held_pc    = bus.out_pc;
      held_inst  = bus.out_inst;
      if (bus.out_valid && bus.out_ready) begin
         top_up();
         e = exp_q.pop_front();
         top_up();
         chk("xfer_pc", bus.out_pc, e.pc);
         chk("xfer_inst", bus.out_inst, e.inst);
         xfers++;
         stall = 0;
      end else if (bus.out_ready && !reset && !in_boot && !redir) begin
         stall++;
         if (stall > 4) begin
            chk("stall_watchdog", 32'(stall), 32'd4);
            stall = 0;
         end
      end else begin
         stall = 0;
      end
   end

   // One clock of stimulus; returns at the following falling edge.
   task automatic cyc(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      reset              = rst;
      bus.out_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      if (rst) restart(RstPc);
      else if (rv && !rst_prev) restart(rpc);
      @(negedge clk);
   endtask

   initial begin
      int          nreq;
      logic [31:0] addrs[$];
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      restart(RstPc);

      // Boot latency and one-per-cycle streaming.
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'd0);
      for (int c = 0; c < 12; c++) begin
         cyc(1'b0, 1'b1, 1'b0, 32'd0);
         if (c >= 1) begin
            chk("a_req_en", 32'(bus.inst_sram_en), 32'd1);
            chk("a_req_addr", bus.inst_sram_addr, RstPc + 32'(4 * (c - 1)));
         end
         if (c == 2) chk("a_valid_early", 32'(bus.out_valid), 32'd0);
         if (c >= 3) chk("a_valid_stream", 32'(bus.out_valid), 32'd1);
         if (c == 3) begin
            chk("a_first_pc", bus.out_pc, RstPc);
            chk("a_first_inst", bus.out_inst, RstPc);
         end
      end

      // Back-pressure from the start: two requests then full.
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'd0);
      nreq = 0;
      for (int c = 0; c < 10; c++) begin
         cyc(1'b0, 1'b0, 1'b0, 32'd0);
         if (bus.inst_sram_en) begin
            nreq++;
            addrs.push_back(bus.inst_sram_addr);
         end
      end
      chk("b_req_count", 32'(nreq), 32'd2);
      if (addrs.size() >= 2) begin
         chk("b_req0", addrs[0], RstPc);
         chk("b_req1", addrs[1], RstPc + 32'd4);
      end
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      chk("b_resume_en", 32'(bus.inst_sram_en), 32'd1);
      chk("b_resume_addr", bus.inst_sram_addr, RstPc + 32'd8);
      repeat (6) cyc(1'b0, 1'b1, 1'b0, 32'd0);

      // Redirect with a full buffer, then one mid-stream with a response in flight.
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 32'h1c00_0203);
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      chk("c_post_redir_valid", 32'(bus.out_valid), 32'd0);
      repeat (6) cyc(1'b0, 1'b1, 1'b0, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 32'h1c00_0103);
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      chk("c_post_redir_valid2", 32'(bus.out_valid), 32'd0);
      repeat (4) cyc(1'b0, 1'b1, 1'b0, 32'd0);

      // Address wrap.
      cyc(1'b0, 1'b1, 1'b1, 32'hffff_fffc);
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      chk("d_wrap_addr0", bus.inst_sram_addr, 32'hffff_fffc);
      chk("d_wrap_en0", 32'(bus.inst_sram_en), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      chk("d_wrap_addr1", bus.inst_sram_addr, 32'h0000_0000);
      chk("d_wrap_en1", 32'(bus.inst_sram_en), 32'd1);
      repeat (4) cyc(1'b0, 1'b1, 1'b0, 32'd0);

      // Reset mid-operation, with the redirect input active to be ignored.
      cyc(1'b1, 1'b1, 1'b1, 32'h2000_0000);
      cyc(1'b0, 1'b1, 1'b1, 32'h3000_0000);
      chk("e_boot_en", 32'(bus.inst_sram_en), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      chk("e_restart_en", 32'(bus.inst_sram_en), 32'd1);
      chk("e_restart_addr", bus.inst_sram_addr, RstPc);
      repeat (4) cyc(1'b0, 1'b1, 1'b0, 32'd0);

      // Random traffic with hashed instruction data.
      hash_mode = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 32'd0);
      xfers = 0;
      for (int i = 0; i < 600; i++) begin
         int          r;
         logic        rst, rv, rdy;
         logic [31:0] rpc;
         r   = int'($urandom_range(0, 99));
         rst = (r < 2);
         rv  = (r >= 2) && (r < 8);
         rdy = ($urandom_range(0, 3) != 0);
         rpc = $urandom;
         if ($urandom_range(0, 7) == 0) rpc = 32'hffff_fff0 + 32'($urandom_range(0, 15));
         cyc(rst, rdy, rv, rpc);
      end
      chk("rand_progress", 32'(xfers > 100), 32'd1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
